// File: rtl/pca9548a_target.sv
// PCA9548A channel-register model: I2C target on oversampled SCL/SDA that
// latches the channel byte on writes and returns it on reads.
module pca9548a_target #(
  parameter logic [6:0] ADDR          = 7'd116,
  parameter logic [7:0] CHANNEL_RESET = 8'h00,
  parameter logic [3:0] FILTER_CYCLES = 4'd3,
  parameter logic [7:0] HOLD_CYCLES   = 8'd30
) (
  input  logic       SYSCLK_IN,
  input  logic       RESET_IN,
  input  logic       I2C_SCLK_IN,
  input  logic       SDI_I2CS,
  output logic       SDO_I2CS,
  output logic       SDT_I2CS,
  output logic [7:0] CHANNEL_OUT,
  output logic       CHANNEL_WE,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic [3:0] scl_cnt_q, sda_cnt_q;
  logic       scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  state_t     state_q;
  logic [7:0] shift_q, chan_q, hold_cnt_q;
  logic [2:0] bit_cnt_q;
  logic       rw_q, we_q, busy_q, sdt_q, pend_q, armed_q;

  logic       scl_rise, scl_fall, start_ev, stop_ev, pend_d;
  logic [7:0] rx_byte;

  // Synchronise, then only accept a new level after FILTER_CYCLES agreeing samples.
  always_ff @(posedge SYSCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], I2C_SCLK_IN};
      sda_sync_q <= {sda_sync_q[0], SDI_I2CS};
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FILTER_CYCLES - 4'd1) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 4'd1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FILTER_CYCLES - 4'd1) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 4'd1;
      end
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  // START/STOP need SCL high on both sides of the SDA edge, so a joint change is a data bit.
  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start_ev = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_ev  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign rx_byte  = {shift_q[6:0], sda_f_q};

  always_comb begin
    pend_d = 1'b1;
    case (state_q)
      S_ADDR_ACK, S_WR_ACK: pend_d = 1'b0;
      S_RD_DATA:            pend_d = shift_q[7];
      default:              pend_d = 1'b1;
    endcase
  end

  always_ff @(posedge SYSCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      chan_q     <= CHANNEL_RESET;
      hold_cnt_q <= '0;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      sdt_q      <= 1'b1;
      pend_q     <= 1'b1;
      armed_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (start_ev) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        busy_q    <= 1'b0;
        sdt_q     <= 1'b1;
        armed_q   <= 1'b0;
      end else if (stop_ev) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        sdt_q   <= 1'b1;
        armed_q <= 1'b0;
      end else begin
        if (scl_rise) begin
          case (state_q)
            S_ADDR: begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (rx_byte[7:1] == ADDR) begin
                  state_q <= S_ADDR_ACK;
                  rw_q    <= rx_byte[0];
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= S_IGNORE;
                end
              end
            end
            S_ADDR_ACK: begin
              bit_cnt_q <= '0;
              if (rw_q) begin
                shift_q <= chan_q;
                state_q <= S_RD_DATA;
              end else begin
                state_q <= S_WR_DATA;
              end
            end
            S_WR_DATA: begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                chan_q  <= rx_byte;
                we_q    <= 1'b1;
                state_q <= S_WR_ACK;
              end
            end
            S_WR_ACK: state_q <= S_WR_DATA;
            S_RD_DATA: begin
              shift_q   <= {shift_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= S_RD_ACK;
            end
            S_RD_ACK: begin
              bit_cnt_q <= '0;
              if (!sda_f_q) begin
                shift_q <= chan_q;
                state_q <= S_RD_DATA;
              end else begin
                state_q <= S_IGNORE;
              end
            end
            default: ;
          endcase
        end
        // SDA changes HOLD_CYCLES after the filtered SCL fall (fall cycle = 0).
        if (scl_fall) begin
          if (HOLD_CYCLES <= 8'd1) begin
            sdt_q <= pend_d;
          end else begin
            pend_q     <= pend_d;
            hold_cnt_q <= 8'd1;
            armed_q    <= 1'b1;
          end
        end else if (armed_q) begin
          if (hold_cnt_q >= HOLD_CYCLES - 8'd1) begin
            sdt_q   <= pend_q;
            armed_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  assign SDO_I2CS    = 1'b0;
  assign SDT_I2CS    = sdt_q;
  assign CHANNEL_OUT = chan_q;
  assign CHANNEL_WE  = we_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_pca9548a_target.sv
// Scoreboarded bench: an I2C initiator drives transactions, a channel-register
// model predicts ACKs, read data and write pulses, and a monitor compares them.
`timescale 1ns/1ps
module tb_pca9548a_target;
  localparam int         Q     = 62;  // quarter SCL period in 10 ns cycles (~400 kHz)
  localparam logic [6:0] TADDR = 7'd116;
  localparam logic [7:0] CRST  = 8'h00;

  logic       clk = 1'b0;
  logic       rst, scl, sda_m, sda_bus;
  logic       sdo, sdt, we, busy;
  logic [7:0] chan;

  always #5 clk = ~clk;
  assign sda_bus = sda_m & (sdt | sdo);

  pca9548a_target #(
    .ADDR(TADDR), .CHANNEL_RESET(CRST), .FILTER_CYCLES(4'd3), .HOLD_CYCLES(8'd30)
  ) dut (
    .SYSCLK_IN(clk), .RESET_IN(rst), .I2C_SCLK_IN(scl), .SDI_I2CS(sda_bus),
    .SDO_I2CS(sdo), .SDT_I2CS(sdt), .CHANNEL_OUT(chan), .CHANNEL_WE(we), .BUSY(busy)
  );

  int         n_chk = 0, n_fail = 0;
  logic [8:0] exp_rsp[$], act_rsp[$];  // bit 8 set = ACK slot, else read byte
  logic [7:0] exp_we[$];
  logic [7:0] m_chan;
  logic       m_match, m_rd;
  logic       busy_seen, sdt_low_seen;
  logic [8:0] mon_a;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (act_rsp.size() > 0) begin
      mon_a = act_rsp.pop_front();
      if (exp_rsp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected: got 0x%0h expected nothing", mon_a);
      end else begin
        check("rsp", 32'(mon_a), 32'(exp_rsp.pop_front()));
      end
    end
    if (we) begin
      if (exp_we.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL we_unexpected: got pulse with 0x%0h expected none", chan);
      end else begin
        check("we_data", 32'(chan), 32'(exp_we.pop_front()));
      end
    end
    busy_seen    = busy_seen | busy;
    sdt_low_seen = sdt_low_seen | ~sdt;
  end

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_slot(input logic b, input logic glitch, output logic s);
    if (glitch) begin
      wq(Q / 2); scl = 1'b1; wq(2); scl = 1'b0; wq(Q - Q / 2 - 2);
    end else begin
      wq(Q);
    end
    sda_m = b; wq(Q); scl = 1'b1; wq(Q); s = sda_bus; wq(Q); scl = 1'b0;
  endtask

  task automatic start_cond();
    sda_m = 1'b1; wq(Q); scl = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl = 1'b0;
    m_match = 1'b0;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wq(Q); scl = 1'b1; wq(Q); sda_m = 1'b1; wq(Q);
    m_match = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_slot(b[i], (i == gbit), s);
    bit_slot(1'b1, 1'b0, ack);
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rw);
    logic ack;
    m_match = (a == TADDR);
    m_rd    = rw;
    exp_rsp.push_back({1'b1, 7'd0, ~m_match});
    send_byte({a, rw}, -1, ack);
    act_rsp.push_back({1'b1, 7'd0, ack});
  endtask

  task automatic wr(input logic [7:0] b, input int gbit);
    logic ack, ok;
    ok = m_match && !m_rd;
    exp_rsp.push_back({1'b1, 7'd0, ~ok});
    if (ok) begin
      exp_we.push_back(b);
      m_chan = b;
    end
    send_byte(b, gbit, ack);
    act_rsp.push_back({1'b1, 7'd0, ack});
  endtask

  task automatic rd(input logic nack);
    logic [7:0] got;
    logic       s, ok;
    ok = m_match && m_rd;
    exp_rsp.push_back({1'b0, (ok ? m_chan : 8'hFF)});
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, 1'b0, s);
      got[i] = s;
    end
    bit_slot(nack, 1'b0, s);
    act_rsp.push_back({1'b0, got});
    if (nack) m_match = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ab;
    logic       s, rw;
    logic [6:0] ra;
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; m_chan = CRST; m_match = 1'b0; m_rd = 1'b0;
    busy_seen = 1'b0; sdt_low_seen = 1'b0;
    wq(5);
    check("rst_sdt", 32'(sdt), 1);
    check("rst_sdo", 32'(sdo), 0);
    check("rst_chan", 32'(chan), 32'(CRST));
    check("rst_we", 32'(we), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    wq(20);

    // single-byte write
    start_cond(); addr_phase(TADDR, 1'b0);
    check("busy_after_addr", 32'(busy), 1);
    wr(8'h08, -1); stop_cond(); wq(20);
    check("busy_after_stop", 32'(busy), 0);
    check("chan_write", 32'(chan), 32'h08);

    // address mismatch
    busy_seen = 1'b0; sdt_low_seen = 1'b0;
    start_cond(); addr_phase(7'h70, 1'b0); wr(8'hFF, -1); stop_cond(); wq(20);
    check("mismatch_busy", 32'(busy_seen), 0);
    check("mismatch_sdt", 32'(sdt_low_seen), 0);
    check("mismatch_chan", 32'(chan), 32'h08);

    // multi-byte write, then two-byte read
    start_cond(); addr_phase(TADDR, 1'b0); wr(8'h01, -1); wr(8'h04, -1); stop_cond();
    start_cond(); addr_phase(TADDR, 1'b1); rd(1'b0); rd(1'b1);
    wq(Q);
    check("sda_released_nack", 32'(sdt), 1);
    stop_cond(); wq(20);
    check("idle_after_read", 32'(busy), 0);

    // repeated START into read
    start_cond(); addr_phase(TADDR, 1'b0); wr(8'h02, -1);
    start_cond(); addr_phase(TADDR, 1'b1); rd(1'b1); stop_cond();

    // SCL glitch mid-byte, then abort after four data bits
    start_cond(); addr_phase(TADDR, 1'b0); wr(8'hA5, 4); stop_cond();
    start_cond(); addr_phase(TADDR, 1'b0);
    bit_slot(1'b1, 1'b0, s); bit_slot(1'b0, 1'b0, s);
    bit_slot(1'b1, 1'b0, s); bit_slot(1'b1, 1'b0, s);
    start_cond(); addr_phase(TADDR, 1'b0); wr(8'h3C, -1); stop_cond(); wq(20);
    check("chan_after_abort", 32'(chan), 32'h3C);

    // reset while the address ACK is being driven
    start_cond();
    ab = {TADDR, 1'b0};
    for (int i = 7; i >= 0; i--) bit_slot(ab[i], 1'b0, s);
    wq(Q);
    check("ack_drive", 32'(sdt), 0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rst_async_sdt", 32'(sdt), 1);
    check("rst_async_chan", 32'(chan), 32'(CRST));
    check("rst_async_busy", 32'(busy), 0);
    m_chan = CRST; m_match = 1'b0;
    wq(3); rst = 1'b0;
    sda_m = 1'b1; wq(Q); scl = 1'b1; wq(Q);
    start_cond(); addr_phase(TADDR, 1'b0); wr(8'h5A, -1); stop_cond(); wq(20);
    check("chan_after_reset_write", 32'(chan), 32'h5A);

    // randomized transactions against the model
    for (int k = 0; k < 4; k++) begin
      ra = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : TADDR;
      rw = 1'($urandom_range(0, 1));
      start_cond(); addr_phase(ra, rw);
      if (rw) rd(1'b1);
      else    wr(8'($urandom), -1);
      stop_cond();
    end
    wq(50);
    check("chan_final", 32'(chan), 32'(m_chan));
    check("we_queue_drained", 32'(exp_we.size()), 0);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pca9548a_target.md
# pca9548a_target

I2C target (responder) that emulates the register behaviour of a PCA9548A 8-channel I2C switch. It watches an oversampled SCL/SDA pair in the SYSCLK_IN domain and ACKs its 7-bit address. On a write it latches the channel-select byte; on a read it returns that byte. It sits on the FPGA's local I2C bus so firmware and initiator blocks can be exercised against a switch model. The latched channel byte is also exported to fabric logic.

## Interface
- ADDR, 7'd116, 7-bit target address.
- CHANNEL_RESET, 8'h00, value of the channel register after reset.
- FILTER_CYCLES, 4'd3, consecutive stable SYSCLK_IN samples required before a filtered line changes (1..15).
- HOLD_CYCLES, 8'd30, SYSCLK_IN cycles from the filtered SCL fall until SDA drive changes (must be less than the SCL low time).

- SYSCLK_IN  in  1  system clock; the only clock.
- RESET_IN  in  1  reset, asynchronous, active-high.
- I2C_SCLK_IN  in  1  SCL from pad.
- SDI_I2CS  in  1  SDA from pad (IOBUF .O).
- SDO_I2CS  out  1  SDA drive value (IOBUF .I); held 0 (open-drain).
- SDT_I2CS  out  1  SDA tristate (IOBUF .T): 1 = released, 0 = pull low.
- CHANNEL_OUT  out  8  current channel register.
- CHANNEL_WE  out  1  one-cycle pulse when CHANNEL_OUT is updated.
- BUSY  out  1  high from address match until STOP, or until a START aborts the transaction.

## Operation
- **Input conditioning.** Each line passes through a 2-FF synchronizer, then a stability counter. The filtered value takes the synchronized value only after FILTER_CYCLES equal consecutive samples.
- **Events.** All events come from the filtered lines:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge.
- **States.**
  - IDLE.
  - ADDR: shift 8 bits, MSB first.
  - ADDR_ACK.
  - WR_DATA → WR_ACK.
  - RD_DATA → RD_ACK.
  - IGNORE.
- **ADDR, after the 8th bit.**
  - Upper 7 bits equal ADDR: R/W=0 → ADDR_ACK then WR_DATA; R/W=1 → ADDR_ACK then RD_DATA, loading the shift register with CHANNEL_OUT.
  - Mismatch → IGNORE; SDA is never driven.
- **WR_DATA, after the 8th bit.**
  - Received byte goes to CHANNEL_OUT on the same cycle as the 8th SCL rise; CHANNEL_WE pulses once.
  - Then WR_ACK, then back to WR_DATA. Every byte overwrites; the last byte wins.
- **RD_DATA.**
  - Present CHANNEL_OUT MSB first. Bit 0 → SDT_I2CS=0; bit 1 → SDT_I2CS=1.
  - RD_ACK samples the initiator: ACK (0) → reload and stay in RD_DATA; NACK (1) → IGNORE.
- **ACK drive.** SDT_I2CS=0 from HOLD_CYCLES after the 8th SCL fall until HOLD_CYCLES after the 9th SCL fall.
- **START in any state** → ADDR (repeated START supported). A partial byte is discarded; CHANNEL_OUT is unchanged; SDA is released immediately.
- **STOP in any state** → IDLE; SDA released; BUSY=0.
- **Reset values.**
  - SDT_I2CS=1, SDO_I2CS=0, CHANNEL_OUT=CHANNEL_RESET, CHANNEL_WE=0, BUSY=0.
  - State IDLE; filters preset to 1.
  - Reset mid-transfer acts immediately, asynchronously.

## Timing
- **Pin to filtered line.** 2 + FILTER_CYCLES cycles. Edge/event detection adds 1 cycle.
- **SDA drive change.** Exactly HOLD_CYCLES cycles after the detected filtered SCL fall, with the filtered-fall cycle counted as 0. This guarantees data hold time after SCL low.
- **CHANNEL_WE.** Asserted the cycle after the internal 8th-bit SCL-rise detect; CHANNEL_OUT is valid in that same cycle.
- **BUSY.** Rises in the cycle the address match is decided; falls in the cycle STOP or an aborting START is detected.
- **Glitches.** SCL/SDA pulses shorter than FILTER_CYCLES cycles are invisible.
- **Simultaneous changes.** If SDA and SCL change in the same filtered cycle, it is not a START/STOP; the bit is sampled with the new SDA.

## Test plan
- **Write.** SCL 400 kHz, SYSCLK 100 MHz. START, 0xE8 (0x74, write), 0x08, STOP → required response:
  - ACK on both bytes.
  - CHANNEL_OUT=0x08; CHANNEL_WE pulses exactly once.
  - BUSY high from the address ACK to STOP.
- **Address mismatch.** START, 0xE0, 0xFF, STOP → SDT_I2CS stays 1 throughout; CHANNEL_OUT unchanged; BUSY stays 0.
- **Multi-byte write then read.**
  - First transaction: START, 0xE8, 0x01, 0x04, STOP → two CHANNEL_WE pulses; CHANNEL_OUT=0x04.
  - Second transaction: START, 0xE9; initiator reads two bytes, ACKing the first and NACKing the second → both bytes read 0x04; SDA released after the NACK; STOP returns to IDLE.
- **Repeated START.** START, 0xE8, 0x02, repeated START, 0xE9, read one byte, NACK, STOP → read returns 0x02.
- **Glitch and abort.**
  - 2-cycle SCL glitch mid-byte (FILTER_CYCLES=3) → no extra bit shifted; byte still received correctly.
  - START after 4 data bits → no CHANNEL_WE; new address phase begins.
- **Reset.** Assert RESET_IN during the ACK drive → SDT_I2CS=1 immediately; CHANNEL_OUT=CHANNEL_RESET; the next full write transaction works normally.
